// File: rtl/rr_arb_pkg.sv
// Shared encodings for the two-channel round-robin packet arbiter.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_out_slice.sv
// Valid/ready output register: loads a muxed beat, holds it under backpressure,
// and drains it when the consumer accepts.
module rr_out_slice #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  output logic              y_valid
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  // load is only possible when the slot is empty or draining, so held data is never overwritten
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q & ~y_ready;
    if (load) begin
      data_d  = in_data;
      last_d  = in_last;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign y_data  = data_q;
  assign y_last  = last_q;
  assign y_valid = valid_q;

endmodule

// File: rtl/rr_arb_2x1.sv
// Two-source round-robin packet arbiter with registered 2:1 mux output.
// Define RR_ARB_GRANT_CNT_EN to add saturating per-source completed-packet counters.
module rr_arb_2x1
  import rr_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 8
`ifdef RR_ARB_GRANT_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  input  logic              a_last,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  input  logic              b_last,
  output logic              b_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_valid,
  output logic              y_last,
  input  logic              y_ready,
  output logic              s,
  output logic              busy
`ifdef RR_ARB_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
`endif
);

  arb_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              s_q, s_d;
  logic              out_free;
  logic              a_acc, b_acc, load;
  logic [DATA_W-1:0] mux_data;
  logic              mux_last;

  assign out_free = ~y_valid | y_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    a_ready = 1'b0;
    b_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // on a tie ptr names the last winner, so the other source goes next
        if (a_valid && (!b_valid || ptr_q == SEL_B)) begin
          state_d = ST_LOCK_A;
          s_d     = SEL_A;
        end else if (b_valid) begin
          state_d = ST_LOCK_B;
          s_d     = SEL_B;
        end
      end
      ST_LOCK_A: begin
        a_ready = out_free;
        if (a_valid && out_free && a_last) begin
          state_d = ST_IDLE;
          ptr_d   = SEL_A;
        end
      end
      ST_LOCK_B: begin
        b_ready = out_free;
        if (b_valid && out_free && b_last) begin
          state_d = ST_IDLE;
          ptr_d   = SEL_B;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= SEL_B;
      s_q     <= SEL_A;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
    end
  end

  assign a_acc    = a_valid & a_ready;
  assign b_acc    = b_valid & b_ready;
  assign load     = a_acc | b_acc;
  assign mux_data = (s_q == SEL_B) ? b_data : a_data;
  assign mux_last = (s_q == SEL_B) ? b_last : a_last;
  assign s        = s_q;
  assign busy     = (state_q != ST_IDLE);

  rr_out_slice #(
    .DATA_W (DATA_W)
  ) u_out_slice (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .in_data (mux_data),
    .in_last (mux_last),
    .y_ready (y_ready),
    .y_data  (y_data),
    .y_last  (y_last),
    .y_valid (y_valid)
  );

`ifdef RR_ARB_GRANT_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (a_acc && a_last && cnt_a_q != CntMax) cnt_a_q <= cnt_a_q + CNT_W'(1);
      if (b_acc && b_last && cnt_b_q != CntMax) cnt_b_q <= cnt_b_q + CNT_W'(1);
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule
